answer_gen: RTL and testbench

- Parametrised answer generator for the guessing game.
- Produces a word of DIGITS packed digits, each in 1..MAX_VAL, from a free-running 32-bit Galois LFSR.
- Optional mode makes all digits distinct.
- A rising edge on change_answer starts one generation; completion writes the new answer and pulses write_enable for the answer store.

---
 rtl/answer_gen_if.sv | 31 +++
 rtl/answer_gen.sv | 153 +++++++++++++++
 tb/tb_answer_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/answer_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : answer_gen_if
// Brief    : Request/answer bundle between the game controller and answer_gen.
// Revision : 1.0  initial release
// ============================================================================
interface answer_gen_if #(
    parameter int DIGITS  = 8,
    parameter int DIGIT_W = 4
);
    // "rand" is a reserved SystemVerilog word, so the answer bus is rand_word.
    logic                        change_answer;
    logic [DIGITS*DIGIT_W-1:0]   rand_word;
    logic                        write_enable;
    logic                        busy;

    modport master (
        output change_answer,
        input  rand_word,
        input  write_enable,
        input  busy
    );

    modport slave (
        input  change_answer,
        output rand_word,
        output write_enable,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/answer_gen.sv
`default_nettype none
// ============================================================================
// Module   : answer_gen
// Brief    : LFSR-driven answer word generator, optional all-distinct digits.
// Revision : 1.0  initial release
// ============================================================================
module answer_gen #(
    parameter int          DIGITS  = 8,
    parameter int          DIGIT_W = 4,
    parameter int          MAX_VAL = 8,
    parameter int          UNIQUE  = 0,
    parameter logic [31:0] SEED    = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    answer_gen_if.slave bus
);
    localparam int                  c_WORD_W     = DIGITS * DIGIT_W;
    localparam int                  c_IDX_W      = $clog2(DIGITS + 1);
    localparam int                  c_MASK_W     = MAX_VAL + 1;
    localparam logic [31:0]         c_SEED       = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0]         c_TAPS       = 32'h8020_0003;
    localparam logic [8:0]          c_MAX        = 9'(MAX_VAL);
    localparam logic [DIGIT_W-1:0]  c_ONE        = DIGIT_W'(1);
    localparam logic [c_WORD_W-1:0] c_RESET_WORD = {DIGITS{c_ONE}};
    localparam logic [c_IDX_W-1:0]  c_LAST       = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE    = c_IDX_W'(1);
    localparam logic [c_MASK_W-1:0] c_MASK_ONE   = c_MASK_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GEN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                w_in_idle;
    logic                w_in_gen;
    logic                w_in_done;

    logic [31:0]         r_lfsr;
    logic [31:0]         w_lfsr_next;
    logic                r_prev_req;
    logic                w_start;

    logic [c_IDX_W-1:0]  r_idx;
    logic [c_MASK_W-1:0] r_used;
    logic [c_WORD_W-1:0] r_shadow;
    logic [c_WORD_W-1:0] r_rand;
    logic                r_we;

    logic [8:0]          w_cand;
    logic [DIGIT_W-1:0]  w_digit;
    logic [c_MASK_W-1:0] w_onehot;
    logic                w_hit;
    logic                w_reject;
    logic                w_accept;
    logic                w_last;

    // Free-running Galois LFSR, never gated by the FSM.
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_TAPS : 32'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= c_SEED;
            r_prev_req <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_prev_req <= bus.change_answer;
        end
    end

    assign w_start = bus.change_answer && !r_prev_req;

    // Candidate digit comes from the pre-advance LFSR value.
    assign w_cand   = ({1'b0, r_lfsr[7:0]} % c_MAX) + 9'd1;
    assign w_digit  = DIGIT_W'(w_cand);
    assign w_onehot = c_MASK_ONE << w_cand;
    assign w_hit    = |(r_used & w_onehot);
    assign w_reject = (UNIQUE != 0) && w_hit;
    assign w_accept = w_in_gen && !w_reject;
    assign w_last   = (r_idx == c_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_next_state = c_GEN;
            c_GEN:   if (w_accept && w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State decode; an illegal encoding behaves as idle.
    always_comb begin
        w_in_idle = 1'b0;
        w_in_gen  = 1'b0;
        w_in_done = 1'b0;
        case (r_state)
            c_IDLE:  w_in_idle = 1'b1;
            c_GEN:   w_in_gen  = 1'b1;
            c_DONE:  w_in_done = 1'b1;
            default: w_in_idle = 1'b1;
        endcase
    end

    // Shadow word is built digit by digit; rand_word only sees complete words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_used   <= '0;
            r_shadow <= c_RESET_WORD;
        end else if (w_in_idle && w_start) begin
            r_idx    <= '0;
            r_used   <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    r_shadow[i*DIGIT_W +: DIGIT_W] <= w_digit;
                end
            end
            r_used <= r_used | w_onehot;
            r_idx  <= r_idx + c_IDX_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rand <= c_RESET_WORD;
            r_we   <= 1'b0;
        end else begin
            r_we <= w_in_done;
            if (w_in_done) begin
                r_rand <= r_shadow;
            end
        end
    end

    assign bus.rand_word    = r_rand;
    assign bus.write_enable = r_we;
    assign bus.busy         = !w_in_idle;

endmodule
`default_nettype wire

// File: tb/tb_answer_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_answer_gen
// Brief    : Directed checks of answer_gen in default, unique and narrow builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_answer_gen;
    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    answer_gen_if #(.DIGITS(8), .DIGIT_W(4)) if0 ();
    answer_gen_if #(.DIGITS(8), .DIGIT_W(4)) if1 ();
    answer_gen_if #(.DIGITS(4), .DIGIT_W(4)) if2 ();

    answer_gen #(.DIGITS(8), .DIGIT_W(4), .MAX_VAL(8), .UNIQUE(0), .SEED(32'h0000_0001))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    answer_gen #(.DIGITS(8), .DIGIT_W(4), .MAX_VAL(8), .UNIQUE(1), .SEED(32'h0000_0001))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    answer_gen #(.DIGITS(4), .DIGIT_W(4), .MAX_VAL(9), .UNIQUE(0), .SEED(32'h0000_ACE1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference LFSR per DUT: reset to its seed, one step per clock.
    logic [31:0] m_lfsr [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr[0] <= 32'h0000_0001;
            m_lfsr[1] <= 32'h0000_0001;
            m_lfsr[2] <= 32'h0000_ACE1;
        end else begin
            for (int i = 0; i < 3; i++) m_lfsr[i] <= lfsr_step(m_lfsr[i]);
        end
    end

    function automatic int dig_of(input int d);
        return (d == 2) ? 4 : 8;
    endfunction
    function automatic int max_of(input int d);
        return (d == 2) ? 9 : 8;
    endfunction
    function automatic bit uniq_of(input int d);
        return (d == 1);
    endfunction

    function automatic logic [31:0] word_of(input int d);
        case (d)
            0:       return if0.rand_word;
            1:       return if1.rand_word;
            default: return {16'h0, if2.rand_word};
        endcase
    endfunction
    function automatic logic we_of(input int d);
        case (d)
            0:       return if0.write_enable;
            1:       return if1.write_enable;
            default: return if2.write_enable;
        endcase
    endfunction
    function automatic logic busy_of(input int d);
        case (d)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    task automatic set_req(input int d, input logic v);
        case (d)
            0:       if0.change_answer = v;
            1:       if1.change_answer = v;
            default: if2.change_answer = v;
        endcase
    endtask

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): actual %h, required %h", name, d, act, exp);
        end
    endtask

    // Expected word from the LFSR value seen at the sampling edge.
    task automatic predict(input logic [31:0] l0, input int digs, input int maxv, input bit uq,
                           output logic [31:0] word, output int rej);
        logic [31:0] l;
        bit [511:0]  used;
        int          i;
        int          c;
        l = l0; used = '0; word = '0; rej = 0; i = 0;
        for (int n = 0; n < 20000 && i < digs; n++) begin
            l = lfsr_step(l);
            c = int'(l[7:0]) % maxv + 1;
            if (uq && used[c]) begin
                rej++;
            end else begin
                used[c] = 1'b1;
                word[i*4 +: 4] = 4'(c);
                i++;
            end
        end
    endtask

    // Caller is at a negedge. Raises change_answer, then observes one generation.
    task automatic run_gen(input int d, input int hold, input int poke, input int exp_lat_in,
                           input logic [31:0] exp_const, input bit use_const);
        logic [31:0] l0, old, exp_w, cur, mask, full;
        int rej, lat, busy_n, pulses, exp_lat, v;
        bit early, ok;
        l0 = m_lfsr[d];
        old = word_of(d);
        predict(l0, dig_of(d), max_of(d), uniq_of(d), exp_w, rej);
        exp_lat = (exp_lat_in > 0) ? exp_lat_in : dig_of(d) + 1 + rej;
        lat = -1; busy_n = 0; pulses = 0; early = 1'b0;
        set_req(d, 1'b1);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (poke > 0) begin
                if (k == 0)        set_req(d, 1'b0);
                if (k == poke)     set_req(d, 1'b1);
                if (k == poke + 1) set_req(d, 1'b0);
            end else if (k + 1 >= hold) begin
                set_req(d, 1'b0);
            end
            if (busy_of(d)) busy_n++;
            if (we_of(d)) begin
                pulses++;
                if (lat < 0) lat = k;
            end else if (lat < 0 && word_of(d) !== old) begin
                early = 1'b1;
            end
            if (lat >= 0 && k >= lat + 3 && k >= hold && k > poke + 1) break;
        end
        set_req(d, 1'b0);
        cur = word_of(d);
        chk("latency", d, lat, exp_lat);
        chk("busy_cycles", d, busy_n, exp_lat);
        chk("we_pulses", d, pulses, 1);
        chk("no_early_update", d, {31'b0, early}, 32'd0);
        chk("word_model", d, cur, exp_w);
        if (use_const) chk("word_const", d, cur, exp_const);
        ok = 1'b1; mask = '0;
        for (int i = 0; i < dig_of(d); i++) begin
            v = int'(cur[i*4 +: 4]);
            if (v < 1 || v > max_of(d)) ok = 1'b0;
            mask[v] = 1'b1;
        end
        chk("digit_range", d, {31'b0, ok}, 32'd1);
        if (uniq_of(d)) begin
            full = 32'h0000_01FE;
            chk("permutation", d, mask, full);
        end
    endtask

    typedef struct {
        int          dut;
        int          gap;
        int          hold;
        int          poke;
        int          exp_lat;
        logic [31:0] exp_word;
        bit          use_const;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int pulses;
        int changes;
        n_tests = 0; n_fail = 0;
        // dut, gap, hold, poke, latency (0 = from model), word, word is a constant
        vecs[0] = '{0, 0, 1,  0, 9, 32'h3423_4234, 1'b1};  // first start after reset
        vecs[1] = '{0, 3, 40, 0, 9, 32'h0, 1'b0};          // level held high
        vecs[2] = '{0, 0, 1,  0, 9, 32'h0, 1'b0};          // new edge after busy drops
        vecs[3] = '{0, 2, 1,  3, 9, 32'h0, 1'b0};          // edge while generating
        vecs[4] = '{0, 1, 1,  8, 9, 32'h0, 1'b0};          // edge during the DONE cycle
        vecs[5] = '{2, 1, 1,  0, 5, 32'h0, 1'b0};
        vecs[6] = '{1, 2, 2,  0, 0, 32'h0, 1'b0};
        vecs[7] = '{0, 4, 12, 0, 9, 32'h0, 1'b0};

        rst_n = 1'b0;
        set_req(0, 1'b0); set_req(1, 1'b0); set_req(2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) set_req(d, i[0]);
        end
        for (int d = 0; d < 3; d++) set_req(d, 1'b0);
        chk("reset_word", 0, word_of(0), 32'h1111_1111);
        chk("reset_word", 1, word_of(1), 32'h1111_1111);
        chk("reset_word", 2, word_of(2), 32'h0000_1111);
        for (int d = 0; d < 3; d++) begin
            chk("reset_we", d, {31'b0, we_of(d)}, 32'd0);
            chk("reset_busy", d, {31'b0, busy_of(d)}, 32'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0; changes = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (we_of(d)) pulses++;
            end
        end
        chk("idle_pulses", 0, pulses, 0);
        chk("idle_word", 0, word_of(0), 32'h1111_1111);
        chk("idle_word", 2, word_of(2), 32'h0000_1111);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (vecs[i].gap) @(negedge clk);
            run_gen(vecs[i].dut, vecs[i].hold, vecs[i].poke, vecs[i].exp_lat,
                    vecs[i].exp_word, vecs[i].use_const);
        end

        for (int n = 0; n < 200; n++) begin
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            run_gen(1, int'($urandom_range(1, 2)), 0, 0, 32'h0, 1'b0);
        end
        for (int n = 0; n < 100; n++) begin
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
            run_gen(2, 1, 0, 5, 32'h0, 1'b0);
        end
        for (int n = 0; n < 20; n++) begin
            repeat (int'($urandom_range(0, 5))) @(negedge clk);
            run_gen(0, int'($urandom_range(1, 15)), 0, 9, 32'h0, 1'b0);
        end

        // Reset in the middle of a generation discards it.
        @(negedge clk);
        set_req(0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) set_req(0, 1'b0);
        end
        chk("midgen_busy", 0, {31'b0, busy_of(0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_word", 0, word_of(0), 32'h1111_1111);
        chk("midrst_word", 2, word_of(2), 32'h0000_1111);
        chk("midrst_we", 0, {31'b0, we_of(0)}, 32'd0);
        chk("midrst_busy", 0, {31'b0, busy_of(0)}, 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (we_of(0)) pulses++;
        end
        chk("midrst_pulses", 0, pulses, 0);
        rst_n = 1'b1;
        run_gen(0, 1, 0, 9, 32'h3423_4234, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
